// File: rtl/envelope_generator.sv
// Linear ADSR envelope generator feeding the amplifier Amplitude input.
// Advances one segment step per Env_ce tick, gated by the note Gate.
module envelope_generator #(
  parameter int unsigned MAX_LEVEL = 32767,
  parameter int unsigned STEP_W    = 16
) (
  input  logic              Sys_clk,
  input  logic              Env_rst_n,
  input  logic              Env_ce,
  input  logic              Gate,
  input  logic [STEP_W-1:0] Attack_step,
  input  logic [STEP_W-1:0] Decay_step,
  input  logic [STEP_W-1:0] Sustain_level,
  input  logic [STEP_W-1:0] Release_step,
  output logic [31:0]       Amplitude,
  output logic [2:0]        Env_state,
  output logic              Env_active,
  output logic              Env_done
);

  localparam int unsigned LVL_W   = 16;
  localparam int unsigned ARITH_W = 17;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ATTACK  = 3'd1;
  localparam logic [2:0] DECAY   = 3'd2;
  localparam logic [2:0] SUSTAIN = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [LVL_W-1:0]   level;
  logic [LVL_W-1:0]   level_nxt;
  logic               gate_prev;
  logic               done;
  logic               done_nxt;
  logic               active;

  logic               rise;
  logic [ARITH_W-1:0] max17;
  logic [ARITH_W-1:0] lvl17;
  logic [ARITH_W-1:0] att17;
  logic [ARITH_W-1:0] dec17;
  logic [ARITH_W-1:0] rel17;
  logic [ARITH_W-1:0] sus17;
  logic [ARITH_W-1:0] s17;
  logic [ARITH_W-1:0] sum17;
  logic               attack_full;
  logic               decay_end;
  logic               release_end;

  // Segment arithmetic in 17 bits so sums and comparisons never wrap.
  assign rise        = Gate & ~gate_prev;
  assign max17       = ARITH_W'(MAX_LEVEL);
  assign lvl17       = ARITH_W'(level);
  assign att17       = ARITH_W'(Attack_step);
  assign dec17       = ARITH_W'(Decay_step);
  assign rel17       = ARITH_W'(Release_step);
  assign sus17       = ARITH_W'(Sustain_level);
  assign s17         = (sus17 > max17) ? max17 : sus17;
  assign sum17       = lvl17 + att17;
  assign attack_full = (sum17 >= max17) || (att17 == '0);
  assign decay_end   = (lvl17 <= s17 + dec17) || (dec17 == '0);
  assign release_end = (lvl17 <= rel17) || (rel17 == '0);

  // State and output registers; ce low freezes everything but the done pulse.
  always_ff @(posedge Sys_clk) begin
    if (!Env_rst_n) begin
      state     <= IDLE;
      level     <= '0;
      gate_prev <= 1'b0;
      done      <= 1'b0;
      active    <= 1'b0;
    end else if (!Env_ce) begin
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      level     <= level_nxt;
      gate_prev <= Gate;
      done      <= done_nxt;
      active    <= (state_nxt != IDLE);
    end
  end

  // Next-state: a gate edge outranks segment completion.
  always_comb begin
    state_nxt = state;
    if (rise) begin
      state_nxt = ATTACK;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        ATTACK:  if (!Gate) state_nxt = RELEASE;
                 else if (attack_full) state_nxt = DECAY;
        DECAY:   if (!Gate) state_nxt = RELEASE;
                 else if (decay_end) state_nxt = SUSTAIN;
        SUSTAIN: if (!Gate) state_nxt = RELEASE;
        RELEASE: if (release_end) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Next level and done: edge ticks hold the level so retriggers never snap to 0.
  always_comb begin
    level_nxt = level;
    done_nxt  = 1'b0;
    if (!rise) begin
      case (state)
        IDLE:    level_nxt = '0;
        ATTACK:  if (Gate) level_nxt = attack_full ? LVL_W'(max17) : LVL_W'(sum17);
        DECAY:   if (Gate) level_nxt = decay_end ? LVL_W'(s17) : LVL_W'(lvl17 - dec17);
        SUSTAIN: if (Gate) level_nxt = LVL_W'(s17);
        RELEASE: begin
          if (release_end) begin
            level_nxt = '0;
            done_nxt  = 1'b1;
          end else begin
            level_nxt = LVL_W'(lvl17 - rel17);
          end
        end
        default: level_nxt = '0;
      endcase
    end
  end

  assign Amplitude  = 32'(level);
  assign Env_state  = state;
  assign Env_active = active;
  assign Env_done   = done;

endmodule
